// File: rtl/flappy_pkg.sv
// Constants and types shared by the bird mover and the collision detector.
package flappy_pkg;

  localparam int SCREEN_H  = 480;
  localparam int BIRD_H    = 56;
  localparam int HIT_CNT_W = 8;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    STROBE = 2'd1,
    GRACE  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_grace_timer.sv
// Loadable 8-bit down-counter stepped once per frame; `expire` marks the step that reaches zero.
module frame_grace_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic       active,
  output logic       expire
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (step && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign active = (count != 8'd0);
  assign expire = step && (count == 8'd1);

endmodule

// File: rtl/bird_collision_detect.sv
// Per-frame bird/pipe hit detector: one collision strobe per hit, then a grace window of whole frames.
// Optional BOUNDARY_HIT_EN: a bird at or below the floor line also counts as a hit.
module bird_collision_detect
  import flappy_pkg::*;
#(
  parameter int GRACE_FRAMES = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 bird_draw_req,
  input  logic                 pipe_draw_req,
  input  logic [31:0]          topLeft_y_bird,
  input  logic                 game_over,
  output logic                 collision,
  output logic [HIT_CNT_W-1:0] hit_count,
  output logic                 grace_active,
  output state_t               fsm_state
);

  localparam logic [HIT_CNT_W-1:0] HIT_MAX = '1;

  // A zero-length grace window would let the FSM strobe on back-to-back frames.
  if (GRACE_FRAMES < 1 || GRACE_FRAMES > 255) begin : g_bad_grace
    $error("bird_collision_detect: GRACE_FRAMES must be in 1..255");
  end

  logic overlap_now;
  logic overlap_flag;
  logic timer_active;
  logic timer_expire;

`ifdef BOUNDARY_HIT_EN
  localparam logic [31:0] FLOOR_Y = 32'(SCREEN_H - BIRD_H);
  assign overlap_now = (bird_draw_req && pipe_draw_req) || (topLeft_y_bird >= FLOOR_Y);
`else
  logic unused_y;
  assign unused_y    = |topLeft_y_bird;
  assign overlap_now = bird_draw_req && pipe_draw_req;
`endif

  frame_grace_timer u_grace (
    .clk      (clk),
    .reset    (reset),
    .load     (fsm_state == STROBE),
    .load_val (8'(GRACE_FRAMES)),
    .step     (startOfFrame),
    .active   (timer_active),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state    <= ARMED;
      overlap_flag <= 1'b0;
      collision    <= 1'b0;
      hit_count    <= '0;
      grace_active <= 1'b0;
    end else begin
      collision <= 1'b0;

      // The frame-closing pulse wins: a same-cycle overlap is judged below, then dropped.
      if (startOfFrame) begin
        overlap_flag <= 1'b0;
      end else if (overlap_now) begin
        overlap_flag <= 1'b1;
      end

      unique case (fsm_state)
        ARMED: begin
          if (startOfFrame && (overlap_flag || overlap_now) && !game_over) begin
            fsm_state <= STROBE;
            collision <= 1'b1;
            if (hit_count != HIT_MAX) begin
              hit_count <= hit_count + 1'b1;
            end
          end
        end
        STROBE: begin
          fsm_state    <= GRACE;
          grace_active <= 1'b1;
        end
        GRACE: begin
          if (timer_expire || !timer_active) begin
            fsm_state    <= ARMED;
            grace_active <= 1'b0;
          end
        end
        default: begin
          fsm_state    <= ARMED;
          grace_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
